// File: rtl/sort_tagged_param.sv
// sort_tagged_param: in-place exchange sorter for N tagged unsigned keys, one compare/swap per cycle
// Ports:
//   i_clk, i_reset           clock and synchronous active-high reset
//   i_start, i_desc          start a job when idle; i_desc=1 sorts descending, sampled at start
//   i_key_in, i_tag_in       N keys / N tags, entry e at [e*W +: W]
//   o_key_out, o_tag_out     working array while busy, sorted array once valid
//   o_busy, o_valid, o_done  sorting, result held until next start, one-cycle completion pulse
module sort_tagged_param #(
  parameter int N     = 5,
  parameter int KEY_W = 19,
  parameter int TAG_W = 3
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_desc,
  input  logic [N*KEY_W-1:0] i_key_in,
  input  logic [N*TAG_W-1:0] i_tag_in,
  output logic [N*KEY_W-1:0] o_key_out,
  output logic [N*TAG_W-1:0] o_tag_out,
  output logic               o_busy,
  output logic               o_valid,
  output logic               o_done
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_J = CW'(N - 1);
  localparam logic [CW-1:0] LAST_I = CW'(N - 2);
  typedef enum logic {IDLE, SORT} state_t;
  state_t r_state, w_state;
  logic [N-1:0][KEY_W-1:0] r_key, w_key;
  logic [N-1:0][TAG_W-1:0] r_tag, w_tag;
  logic [CW-1:0] r_i, r_j, w_i, w_j;
  logic r_desc, w_desc, r_valid, w_valid, r_done, w_done;
  logic [KEY_W-1:0] w_ki, w_kj;
  logic [TAG_W-1:0] w_ti, w_tj;
  logic w_swap;
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_key   <= '0;
      r_tag   <= '0;
      r_i     <= '0;
      r_j     <= CW'(1);
      r_desc  <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_key   <= w_key;
      r_tag   <= w_tag;
      r_i     <= w_i;
      r_j     <= w_j;
      r_desc  <= w_desc;
      r_valid <= w_valid;
      r_done  <= w_done;
    end
  end
  always_comb begin
    w_state = r_state;
    w_key   = r_key;
    w_tag   = r_tag;
    w_i     = r_i;
    w_j     = r_j;
    w_desc  = r_desc;
    w_valid = r_valid;
    w_done  = 1'b0;
    w_ki    = r_key[r_i];
    w_kj    = r_key[r_j];
    w_ti    = r_tag[r_i];
    w_tj    = r_tag[r_j];
    w_swap  = r_desc ? (w_ki < w_kj) : (w_ki > w_kj);
    if (r_state == IDLE) begin
      if (i_start) begin
        w_key   = i_key_in;
        w_tag   = i_tag_in;
        w_desc  = i_desc;
        w_i     = '0;
        w_j     = CW'(1);
        w_valid = 1'b0;
        w_state = SORT;
      end
    end else begin
      if (w_swap) begin
        w_key[r_i] = w_kj;
        w_key[r_j] = w_ki;
        w_tag[r_i] = w_tj;
        w_tag[r_j] = w_ti;
      end
      if (r_j != LAST_J) w_j = r_j + CW'(1);
      else if (r_i != LAST_I) begin
        w_i = r_i + CW'(1);
        w_j = r_i + CW'(2);
      end else begin
        w_state = IDLE;
        w_valid = 1'b1;
        w_done  = 1'b1;
      end
    end
  end
  assign o_key_out = r_key;
  assign o_tag_out = r_tag;
  assign o_busy    = (r_state == SORT);
  assign o_valid   = r_valid;
  assign o_done    = r_done;
endmodule

// File: tb/tb_sort_tagged_param.sv
// tb_sort_tagged_param: directed and random checks of sort_tagged_param against a pairwise-exchange reference
module tb_sort_tagged_param;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start5 = 1'b0, desc5 = 1'b0, busy5, valid5, done5;
  logic [4:0][18:0] ki5 = '0, ko5;
  logic [4:0][2:0]  ti5 = '0, to5;
  logic start8 = 1'b0, desc8 = 1'b0, busy8, valid8, done8;
  logic [7:0][3:0] ki8 = '0, ko8;
  logic [7:0][2:0] ti8 = '0, to8;
  int passed = 0, total = 0;
  sort_tagged_param dut5 (
    .i_clk(clk), .i_reset(rst), .i_start(start5), .i_desc(desc5),
    .i_key_in(ki5), .i_tag_in(ti5), .o_key_out(ko5), .o_tag_out(to5),
    .o_busy(busy5), .o_valid(valid5), .o_done(done5));
  sort_tagged_param #(.N(8), .KEY_W(4), .TAG_W(3)) dut8 (
    .i_clk(clk), .i_reset(rst), .i_start(start8), .i_desc(desc8),
    .i_key_in(ki8), .i_tag_in(ti8), .o_key_out(ko8), .o_tag_out(to8),
    .o_busy(busy8), .o_valid(valid8), .o_done(done8));
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask
  function automatic void model(input int n, input bit d, inout int k[8], inout int t[8]);
    int x;
    for (int a = 0; a < n - 1; a++)
      for (int b = a + 1; b < n; b++)
        if (d ? (k[a] < k[b]) : (k[a] > k[b])) begin
          x = k[a]; k[a] = k[b]; k[b] = x;
          x = t[a]; t[a] = t[b]; t[b] = x;
        end
  endfunction
  task automatic drive(input bit b8, input bit d, input int k[8], input int t[8]);
    for (int e = 0; e < 8; e++)
      if (b8) begin
        ki8[e] = 4'(k[e]); ti8[e] = 3'(t[e]);
      end else if (e < 5) begin
        ki5[e] = 19'(k[e]); ti5[e] = 3'(t[e]);
      end
    if (b8) desc8 = d; else desc5 = d;
  endtask
  task automatic load(input bit b8, input bit d, input int k[8], input int t[8]);
    @(negedge clk);
    drive(b8, d, k, t);
    if (b8) start8 = 1'b1; else start5 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    start5 = 1'b0;
  endtask
  task automatic wait_done(input bit b8, input int p, input string tag);
    int n = 0, bc = 0;
    while (!(b8 ? done8 : done5) && n < 100) begin
      if (b8 ? busy8 : busy5) bc++;
      @(negedge clk);
      n++;
    end
    chk({tag, "_latency"}, n, p);
    chk({tag, "_busy_cycles"}, bc, p);
    chk({tag, "_valid"}, b8 ? valid8 : valid5, 1);
  endtask
  task automatic chk_res(input bit b8, input bit d, input int k[8], input int t[8], input string tag);
    logic [4:0][18:0] ek5;
    logic [4:0][2:0]  et5;
    logic [7:0][3:0]  ek8;
    logic [7:0][2:0]  et8;
    model(b8 ? 8 : 5, d, k, t);
    for (int e = 0; e < 8; e++)
      if (b8) begin
        ek8[e] = 4'(k[e]); et8[e] = 3'(t[e]);
      end else if (e < 5) begin
        ek5[e] = 19'(k[e]); et5[e] = 3'(t[e]);
      end
    if (b8) begin
      chk({tag, "_keys"}, ko8, ek8);
      chk({tag, "_tags"}, to8, et8);
    end else begin
      chk({tag, "_keys"}, ko5, ek5);
      chk({tag, "_tags"}, to5, et5);
    end
  endtask
  task automatic job(input bit b8, input bit d, input int k[8], input int t[8], input string tag);
    load(b8, d, k, t);
    wait_done(b8, b8 ? 28 : 10, tag);
    chk_res(b8, d, k, t, tag);
  endtask
  int t1k[8], t1t[8], tb5[8], t6k[8], rk[8], rt[8], ones[8];
  logic [4:0][18:0] lk;
  logic [4:0][2:0]  lt;
  initial begin
    t1k = '{7, 3, 9, 3, 1, 0, 0, 0};
    t1t = '{0, 1, 2, 3, 4, 0, 0, 0};
    tb5 = '{5, 5, 5, 5, 5, 0, 0, 0};
    t6k = '{15, 0, 15, 8, 0, 1, 2, 15};
    ones = '{1, 2, 3, 4, 5, 0, 0, 0};
    repeat (2) @(negedge clk);
    chk("rst_keys", ko5, 0);
    chk("rst_tags", to5, 0);
    chk("rst_flags", {busy5, valid5, done5, busy8, valid8, done8}, 0);
    rst = 1'b0;
    // T1: descending, with literal expectations as well as the reference model
    job(0, 1, t1k, t1t, "t1");
    lk = {19'd1, 19'd3, 19'd3, 19'd7, 19'd9};
    lt = {3'd4, 3'd3, 3'd1, 3'd0, 3'd2};
    chk("t1_lit_keys", ko5, lk);
    chk("t1_lit_tags", to5, lt);
    chk("t1_done_pulse_now", done5, 1);
    @(negedge clk);
    chk("t1_done_drop", done5, 0);
    chk("t1_valid_held", valid5, 1);
    // T2: ascending
    job(0, 0, t1k, t1t, "t2");
    lk = {19'd9, 19'd7, 19'd3, 19'd3, 19'd1};
    lt = {3'd2, 3'd0, 3'd1, 3'd3, 3'd4};
    chk("t2_lit_keys", ko5, lk);
    chk("t2_lit_tags", to5, lt);
    // T3: start mid-SORT ignored
    load(0, 1, tb5, t1t);
    repeat (2) @(negedge clk);
    drive(0, 0, ones, ones);
    start5 = 1'b1;
    @(negedge clk);
    start5 = 1'b0;
    wait_done(0, 7, "t3");
    chk_res(0, 1, tb5, t1t, "t3");
    // T4: reset at the fourth compare cycle
    load(0, 1, t1k, t1t);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t4_keys", ko5, 0);
    chk("t4_tags", to5, 0);
    chk("t4_flags", {busy5, valid5, done5}, 0);
    @(negedge clk);
    chk("t4_idle", busy5, 0);
    job(0, 1, t1k, t1t, "t4_rerun");
    // T5: start held across done; second job loads on the done cycle with new desc
    @(negedge clk);
    drive(0, 1, t1k, t1t);
    start5 = 1'b1;
    @(negedge clk);
    drive(0, 0, tb5, ones);
    wait_done(0, 10, "t5a");
    chk_res(0, 1, t1k, t1t, "t5a");
    @(negedge clk);
    start5 = 1'b0;
    chk("t5_valid_drop", valid5, 0);
    chk("t5_reloaded", busy5, 1);
    wait_done(0, 10, "t5b");
    chk_res(0, 0, tb5, ones, "t5b");
    // T6: N=8, both directions
    job(1, 1, t6k, ones, "t6_desc");
    job(1, 0, t6k, ones, "t6_asc");
    // random jobs with duplicate-heavy keys and extreme values
    for (int r = 0; r < 12; r++) begin
      for (int e = 0; e < 8; e++) begin
        case ($urandom_range(0, 3))
          0: rk[e] = 0;
          1: rk[e] = 19'h7ffff;
          2: rk[e] = $urandom_range(0, 3);
          default: rk[e] = $urandom_range(0, 19'h7ffff);
        endcase
        rt[e] = $urandom_range(0, 7);
      end
      job(0, 1'($urandom_range(0, 1)), rk, rt, "rand5");
      for (int e = 0; e < 8; e++) rk[e] = rk[e] & 15;
      job(1, 1'($urandom_range(0, 1)), rk, rt, "rand8");
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
